// File: rtl/qei_multi.sv
// Multi-channel quadrature encoder interface: per-channel sync/filter, 4x decode,
// index latch and error counting, with a 16-word memory-mapped register port.
module qei_multi #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enc_a,
  input  logic [CHANNELS-1:0] enc_b,
  input  logic [CHANNELS-1:0] enc_z,
  input  logic [3:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] index_irq
);

  localparam logic [4:0] FL = 5'(FILT_LEN);

  logic [1:0]  sync_vld;
  logic [31:0] reg_word [CHANNELS][4];
  logic [31:0] rd_word;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:4];

  // Filters ignore the synchroniser contents until real pin samples have reached them
  always_ff @(posedge clk) begin
    if (!reset_n) sync_vld <= '0;
    else          sync_vld <= {sync_vld[0], 1'b1};
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [2:0]      sync1, sync2, cand, filt;
    logic [2:0][4:0] run;
    logic            primed, z_prev;
    logic [1:0]      prev_ab, cur_ab, g_cur, g_prev;
    logic [CNT_W-1:0] pos, idx_pos;
    logic            index_seen, error, rst_on_index, invert_dir;
    logic [7:0]      err_cnt;
    logic            wr_ctrl, zero_pos, clr_status, changed, illegal, step, step_up, z_rise, ready;
    logic [31:0]     pos_w, idx_w;

    // Gray position 00,10,11,01 -> 0,1,2,3 so a forward step is a +1 modulo 4
    always_comb begin
      cur_ab     = {filt[0], filt[1]};
      g_cur      = {cur_ab[0], cur_ab[1] ^ cur_ab[0]};
      g_prev     = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
      changed    = primed && (cur_ab != prev_ab);
      illegal    = changed && ((cur_ab ^ prev_ab) == 2'b11);
      step       = changed && !illegal;
      step_up    = ((g_cur - g_prev) == 2'd1) ^ invert_dir;
      z_rise     = filt[2] && !z_prev;
      ready      = (run[0] >= FL) && (run[1] >= FL);
      wr_ctrl    = write && (address == {2'(g), 2'd3});
      zero_pos   = wr_ctrl && writedata[0];
      clr_status = wr_ctrl && writedata[1];
      pos_w      = '0;
      pos_w[CNT_W-1:0] = pos;
      idx_w      = '0;
      idx_w[CNT_W-1:0] = idx_pos;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync1 <= '0; sync2 <= '0; cand <= '0; filt <= '0; run <= '0;
        primed <= 1'b0; z_prev <= 1'b0; prev_ab <= '0;
        pos <= '0; idx_pos <= '0; index_seen <= 1'b0; error <= 1'b0; err_cnt <= '0;
        rst_on_index <= 1'b0; invert_dir <= 1'b0;
      end else begin
        sync1 <= {enc_z[g], enc_b[g], enc_a[g]};
        sync2 <= sync1;
        // run counts consecutive samples equal to cand; filt follows once the run is long enough
        if (sync_vld[1]) begin
          for (int k = 0; k < 3; k++) begin
            if (sync2[k] == cand[k]) begin
              if (run[k] < FL) run[k] <= run[k] + 5'd1;
              if (run[k] + 5'd1 >= FL) filt[k] <= cand[k];
            end else begin
              cand[k] <= sync2[k];
              run[k]  <= 5'd1;
              if (FL == 5'd1) filt[k] <= sync2[k];
            end
          end
        end
        z_prev <= filt[2];
        if (primed) prev_ab <= cur_ab;
        else if (ready) begin
          primed  <= 1'b1;
          prev_ab <= cur_ab;
        end
        if (zero_pos)                     pos <= '0;
        else if (z_rise && rst_on_index)  pos <= '0;
        else if (step)                    pos <= step_up ? pos + CNT_W'(1) : pos - CNT_W'(1);
        if (z_rise) idx_pos <= pos;
        index_seen <= z_rise || (index_seen && !clr_status);
        error      <= illegal || (error && !clr_status);
        if (clr_status)                      err_cnt <= illegal ? 8'd1 : 8'd0;
        else if (illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (wr_ctrl) {invert_dir, rst_on_index} <= writedata[3:2];
      end
    end

    assign reg_word[g][0] = pos_w;
    assign reg_word[g][1] = idx_w;
    assign reg_word[g][2] = {16'd0, err_cnt, 6'd0, error, index_seen};
    assign reg_word[g][3] = {28'd0, invert_dir, rst_on_index, 2'b00};
    assign index_irq[g]   = index_seen;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (address[3:2] == 2'(i)) rd_word = reg_word[i][address[1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  readdata <= '0;
    else if (read) readdata <= rd_word;
  end

endmodule
